pwm_mod_ctrl: RTL

Sequencer for the PWM comparator's duty-cycle (`mod`) input in the DDS synthesizer. Accepts a new duty target over a valid/ready handshake and glides the live `mod` value toward it by a programmable step. `mod` only ever changes at phase-accumulator wrap (period boundary), so every PWM period is glitch-free. An optional compile-time sweep mode turns the block into a triangle LFO on duty cycle.

---
 rtl/pwm_mod_ctrl_if.sv | 10 +
 rtl/pwm_mod_ctrl.sv | 98 +++++++++
 2 files changed

// File: rtl/pwm_mod_ctrl_if.sv
// pwm_mod_ctrl_if: duty-target configuration handshake into pwm_mod_ctrl
interface pwm_mod_ctrl_if #(parameter int M = 12);
  logic         cfg_valid;
  logic         cfg_ready;
  logic         cfg_sweep;
  logic [M-1:0] cfg_target;
  logic [M-1:0] cfg_step;
  modport master (output cfg_valid, cfg_target, cfg_step, cfg_sweep, input cfg_ready);
  modport slave (input cfg_valid, cfg_target, cfg_step, cfg_sweep, output cfg_ready);
endinterface

// File: rtl/pwm_mod_ctrl.sv
// pwm_mod_ctrl: glides PWM duty toward a target once per phase wrap; PWM_LFO_EN adds a triangle sweep mode
module pwm_mod_ctrl #(
  parameter int N = 14,
  parameter int M = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  phase,
  pwm_mod_ctrl_if.slave cfg,
  output logic [M-1:0]  mod,
  output logic          busy
);
`ifdef PWM_LFO_EN
  typedef enum logic [1:0] {IDLE, GLIDE, SWEEP} state_t;
`else
  typedef enum logic [1:0] {IDLE, GLIDE} state_t;
`endif
  state_t       state_q, state_d;
  logic         prev_msb_q;
  logic [M-1:0] mod_q, mod_d, tgt_q, tgt_d, step_q, step_d, diff;
  logic         wrap, accept, done, unused_ok;
`ifdef PWM_LFO_EN
  logic [M-1:0] lo_q, lo_d, hi_q, hi_d;
  logic         dir_q, dir_d, up_end, dn_end;
  assign up_end = hi_q - mod_q <= step_q;
  assign dn_end = mod_q - lo_q <= step_q;
`endif
  assign wrap = prev_msb_q & ~phase[N-1];
  assign cfg.cfg_ready = state_q != GLIDE;
  assign accept = cfg.cfg_valid & cfg.cfg_ready;
  assign diff = tgt_q >= mod_q ? tgt_q - mod_q : mod_q - tgt_q;
  assign done = step_q == '0 || diff <= step_q;
  assign mod = mod_q;
  assign busy = state_q != IDLE;
  assign unused_ok = ^{phase[N-2:0], cfg.cfg_sweep};
  always_comb begin
    state_d = state_q;
    mod_d = mod_q;
    tgt_d = tgt_q;
    step_d = step_q;
`ifdef PWM_LFO_EN
    lo_d = lo_q;
    hi_d = hi_q;
    dir_d = dir_q;
`endif
    if (accept) begin
      tgt_d = cfg.cfg_target;
      step_d = cfg.cfg_step;
      state_d = GLIDE;
`ifdef PWM_LFO_EN
      if (cfg.cfg_sweep) begin
        step_d = cfg.cfg_step == '0 ? M'(1) : cfg.cfg_step;
        state_d = SWEEP;
        lo_d = cfg.cfg_target < mod_q ? cfg.cfg_target : mod_q;
        hi_d = cfg.cfg_target < mod_q ? mod_q : cfg.cfg_target;
        dir_d = cfg.cfg_target >= mod_q;
      end
`endif
    end else if (wrap && state_q == GLIDE) begin
      mod_d = done ? tgt_q : tgt_q > mod_q ? mod_q + step_q : mod_q - step_q;
      state_d = done ? IDLE : GLIDE;
    end
`ifdef PWM_LFO_EN
    else if (wrap && state_q == SWEEP) begin
      mod_d = dir_q ? (up_end ? hi_q : mod_q + step_q) : (dn_end ? lo_q : mod_q - step_q);
      dir_d = dir_q ? !up_end : dn_end;
    end
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      prev_msb_q <= 1'b0;
      mod_q <= '0;
      tgt_q <= '0;
      step_q <= '0;
    end else begin
      state_q <= state_d;
      prev_msb_q <= phase[N-1];
      mod_q <= mod_d;
      tgt_q <= tgt_d;
      step_q <= step_d;
    end
  end
`ifdef PWM_LFO_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      lo_q <= '0;
      hi_q <= '0;
      dir_q <= 1'b0;
    end else begin
      lo_q <= lo_d;
      hi_q <= hi_d;
      dir_q <= dir_d;
    end
  end
`endif
endmodule
